// File: rtl/regfile_dump_reader_if.sv
// Byte stream carrying serialised register frames from the dump reader to the debug path.
interface regfile_dump_reader_if;
  logic [7:0] byte_out;
  logic       byte_valid;
  logic       byte_ready;

  modport master (output byte_out, output byte_valid, input byte_ready);
  modport slave  (input byte_out, input byte_valid, output byte_ready);
endinterface

// File: rtl/regfile_dump_reader.sv
// Walks a register index range and emits {idx, data[7:0..31:24]} frames; first byte 2 cycles after start,
// 6 cycles per register at full rate; byte_out/byte_valid hold while byte_ready is low, only abort/clr drop them.
module regfile_dump_reader #(
  parameter int DATA_W = 32,
  parameter int IDX_W  = 5
) (
  input  logic              clk,
  input  logic              clr,
  input  logic              start,
  input  logic [IDX_W-1:0]  first_idx,
  input  logic [IDX_W-1:0]  last_idx,
  input  logic              abort,
  output logic [IDX_W-1:0]  rd_idx,
  input  logic [DATA_W-1:0] rd_data,
  regfile_dump_reader_if.master bs,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {IDLE, READ, SEND, DONE} state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   cur_idx;
  logic [IDX_W-1:0]   last_q;
  logic [DATA_W-1:0]  shadow;
  logic [2:0]         byte_cnt;
  logic               xfer;
  logic               frame_end;

  assign xfer      = bs.byte_valid & bs.byte_ready;
  assign frame_end = xfer && (byte_cnt == 3'd4);
  // cur_idx only moves on the way into READ, so it doubles as the held read address.
  assign rd_idx    = cur_idx;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (first_idx <= last_idx) ? READ : DONE;
        end
      end
      READ: state_nxt = abort ? IDLE : SEND;
      SEND: begin
        if (abort) begin
          state_nxt = IDLE;
        end else if (frame_end) begin
          state_nxt = (cur_idx == last_q) ? DONE : READ;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      cur_idx  <= '0;
      last_q   <= '0;
      shadow   <= '0;
      byte_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && (first_idx <= last_idx)) begin
            cur_idx <= first_idx;
            last_q  <= last_idx;
          end
        end
        READ: begin
          if (!abort) begin
            shadow   <= rd_data;
            byte_cnt <= 3'd0;
          end
        end
        SEND: begin
          if (!abort && xfer) begin
            if (byte_cnt == 3'd4) begin
              byte_cnt <= 3'd0;
              // Stop on last_q before incrementing so index 31 never wraps.
              if (cur_idx != last_q) begin
                cur_idx <= cur_idx + {{(IDX_W-1){1'b0}}, 1'b1};
              end
            end else begin
              byte_cnt <= byte_cnt + 3'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    bs.byte_valid = (state == SEND);
    bs.byte_out   = 8'h00;
    if (state == SEND) begin
      case (byte_cnt)
        3'd0:    bs.byte_out = {{(8-IDX_W){1'b0}}, cur_idx};
        3'd1:    bs.byte_out = shadow[7:0];
        3'd2:    bs.byte_out = shadow[15:8];
        3'd3:    bs.byte_out = shadow[23:16];
        3'd4:    bs.byte_out = shadow[31:24];
        default: bs.byte_out = 8'h00;
      endcase
    end
    busy = (state == READ) || (state == SEND);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Randomised scoreboard bench for regfile_dump_reader: expected bytes/done pulses are queued at start, a negedge monitor consumes them.
module tb_regfile_dump_reader;
  logic        clk = 1'b0;
  logic        clr;
  logic        start;
  logic [4:0]  first_idx;
  logic [4:0]  last_idx;
  logic        abort;
  logic [4:0]  rd_idx;
  logic [31:0] rd_data;
  logic        busy;
  logic        done;
  logic [31:0] regs [32];

  regfile_dump_reader_if bs_if ();

  regfile_dump_reader #(.DATA_W(32), .IDX_W(5)) dut (
    .clk(clk), .clr(clr), .start(start), .first_idx(first_idx), .last_idx(last_idx),
    .abort(abort), .rd_idx(rd_idx), .rd_data(rd_data), .bs(bs_if), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  assign rd_data = regs[rd_idx];

  int          checks = 0;
  int          failures = 0;
  int          xfer_cnt = 0;
  int          done_exp = 0;
  logic [7:0]  exp_q [$];
  logic        prev_stall = 1'b0;
  logic        prev_abort = 1'b0;
  logic [7:0]  prev_byte = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a dump is the concatenation of {idx, LSB..MSB} per register, then one done pulse.
  task automatic push_frame(input int i);
    logic [31:0] v;
    v = regs[i];
    exp_q.push_back(8'(i));
    for (int b = 0; b < 4; b++) exp_q.push_back(v[8*b +: 8]);
  endtask

  task automatic push_dump(input int f, input int l);
    if (f <= l) begin
      for (int i = f; i <= l; i++) push_frame(i);
    end
    done_exp++;
  endtask

  task automatic pulse_start(input int f, input int l);
    @(posedge clk); #1;
    start = 1'b1; first_idx = 5'(f); last_idx = 5'(l);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic wait_drain(input string name, input bit rnd);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 3000 && !ok; n++) begin
      bs_if.byte_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      // The register being sent is already in the shadow; overwriting it must not disturb the frame.
      if (rnd && bs_if.byte_valid) regs[rd_idx] = $urandom;
      @(negedge clk);
      ok = (exp_q.size() == 0) && (done_exp == 0);
      if (!ok) begin
        @(posedge clk); #1;
      end
    end
    chk(name, 32'(ok), 32'd1);
  endtask

  always @(negedge clk) begin
    if (!clr) begin
      prev_stall = 1'b0;
      prev_abort = 1'b0;
    end else begin
      if (prev_stall && !prev_abort) begin
        chk("hold_valid", 32'(bs_if.byte_valid), 32'd1);
        chk("hold_byte", 32'(bs_if.byte_out), 32'(prev_byte));
      end
      if (bs_if.byte_valid && bs_if.byte_ready) begin
        xfer_cnt++;
        if (exp_q.size() == 0) begin
          chk("unexpected_byte", 32'(bs_if.byte_out), 32'hFFFF_FFFF);
        end else begin
          chk("stream_byte", 32'(bs_if.byte_out), 32'(exp_q.pop_front()));
        end
      end
      if (done) begin
        chk("done_expected", 32'(done_exp > 0), 32'd1);
        if (done_exp > 0) done_exp--;
      end
      prev_stall = bs_if.byte_valid && !bs_if.byte_ready;
      prev_byte  = bs_if.byte_out;
      prev_abort = abort;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int busy_n, valid_n, done_n, fv, dn, base;
    bit reached;
    clr = 1'b0; start = 1'b0; abort = 1'b0; first_idx = '0; last_idx = '0;
    bs_if.byte_ready = 1'b0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    #3;
    chk("rst_valid", 32'(bs_if.byte_valid), 32'd0);
    chk("rst_byte", 32'(bs_if.byte_out), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_rd_idx", 32'(rd_idx), 32'd0);
    @(negedge clk); clr = 1'b1;

    // Single register: latency and frame shape.
    regs[3] = 32'hDEADBEEF;
    bs_if.byte_ready = 1'b1;
    push_dump(3, 3);
    pulse_start(3, 3);
    busy_n = 0; fv = -1; dn = -1;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (bs_if.byte_valid && fv < 0) fv = k;
      if (done && dn < 0) dn = k;
    end
    chk("t1_busy_cycles", 32'(busy_n), 32'd6);
    chk("t1_first_valid", 32'(fv), 32'd2);
    chk("t1_done_cycle", 32'(dn), 32'd7);
    chk("t1_drained", 32'(exp_q.size() + done_exp), 32'd0);

    // Full sweep.
    for (int i = 0; i < 32; i++) regs[i] = 32'h01010101 * i;
    push_dump(0, 31);
    pulse_start(0, 31);
    busy_n = 0; done_n = 0;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (done) done_n++;
    end
    chk("t2_busy_cycles", 32'(busy_n), 32'd192);
    chk("t2_done_pulses", 32'(done_n), 32'd1);
    chk("t2_drained", 32'(exp_q.size() + done_exp), 32'd0);

    // Backpressure on the third byte.
    regs[3] = 32'hDEADBEEF;
    base = xfer_cnt;
    push_dump(3, 3);
    pulse_start(3, 3);
    reached = 1'b0;
    for (int n = 0; n < 20 && !reached; n++) begin
      if (xfer_cnt - base == 2) reached = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t3_reached", 32'(reached), 32'd1);
    bs_if.byte_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk("t3_stall_valid", 32'(bs_if.byte_valid), 32'd1);
      chk("t3_stall_byte", 32'(bs_if.byte_out), 32'hBE);
    end
    @(posedge clk); #1;
    wait_drain("t3_drain", 1'b0);

    // Empty range.
    push_dump(5, 2);
    pulse_start(5, 2);
    busy_n = 0; valid_n = 0; dn = -1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (busy) busy_n++;
      if (bs_if.byte_valid) valid_n++;
      if (done && dn < 0) dn = k;
    end
    chk("t4_busy", 32'(busy_n), 32'd0);
    chk("t4_valid", 32'(valid_n), 32'd0);
    chk("t4_done_cycle", 32'(dn), 32'd1);
    chk("t4_drained", 32'(exp_q.size() + done_exp), 32'd0);

    // Abort during frame 2 byte 1, with an ignored start while busy.
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    base = xfer_cnt;
    push_frame(0); push_frame(1); exp_q.push_back(8'd2);
    pulse_start(0, 7);
    reached = 1'b0;
    for (int n = 0; n < 100 && !reached; n++) begin
      if (xfer_cnt - base == 11) reached = 1'b1;
      else begin
        start = (xfer_cnt - base == 3); first_idx = 5'd20; last_idx = 5'd25;
        @(posedge clk); #1;
      end
    end
    start = 1'b0;
    chk("t5_reached", 32'(reached), 32'd1);
    bs_if.byte_ready = 1'b0; abort = 1'b1;
    @(negedge clk);
    chk("t5_abort_cycle_valid", 32'(bs_if.byte_valid), 32'd1);
    chk("t5_abort_cycle_byte", 32'(bs_if.byte_out), 32'(regs[2][7:0]));
    @(posedge clk); #1;
    abort = 1'b0; bs_if.byte_ready = 1'b1;
    @(negedge clk);
    chk("t5_valid_after_abort", 32'(bs_if.byte_valid), 32'd0);
    chk("t5_busy_after_abort", 32'(busy), 32'd0);
    repeat (5) @(negedge clk);
    chk("t5_drained", 32'(exp_q.size() + done_exp), 32'd0);
    push_dump(4, 6);
    pulse_start(4, 6);
    wait_drain("t5_restart", 1'b0);

    // Asynchronous clear mid-frame.
    base = xfer_cnt;
    push_dump(0, 3);
    pulse_start(0, 3);
    reached = 1'b0;
    for (int n = 0; n < 100 && !reached; n++) begin
      if (xfer_cnt - base == 7) reached = 1'b1;
      else begin @(posedge clk); #1; end
    end
    chk("t6_reached", 32'(reached), 32'd1);
    #2 clr = 1'b0;
    #1;
    chk("t6_clr_valid", 32'(bs_if.byte_valid), 32'd0);
    chk("t6_clr_busy", 32'(busy), 32'd0);
    chk("t6_clr_done", 32'(done), 32'd0);
    chk("t6_clr_rd_idx", 32'(rd_idx), 32'd0);
    exp_q.delete();
    done_exp = 0;
    @(negedge clk); #2 clr = 1'b1;
    push_dump(7, 7);
    pulse_start(7, 7);
    wait_drain("t6_after_clr", 1'b0);

    // Random ranges, random backpressure, writes to the register in flight.
    for (int t = 0; t < 12; t++) begin
      int f, l;
      for (int i = 0; i < 32; i++) regs[i] = $urandom;
      f = $urandom_range(0, 31);
      l = (t % 4 == 3) ? $urandom_range(0, 31) : $urandom_range(f, 31);
      push_dump(f, l);
      pulse_start(f, l);
      wait_drain("rand_dump", 1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
